// File: rtl/change_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : change_event_monitor
// Brief    : Counts cycles in which sig_in differs from its previous sample over
//            a programmed window, then offers the total on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module change_event_monitor #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 32,
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIN_W-1:0] window,
    input  logic [WIDTH-1:0] sig_in,
    output logic             busy,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_sat,
    output logic [WIDTH-1:0] last_val
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [WIN_W-1:0] c_win_one = WIN_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [WIN_W-1:0] r_remaining;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic [WIDTH-1:0] r_last;
    logic             w_change;

    // Any differing bit is a single event; this is not a popcount.
    assign w_change = (sig_in != r_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (window == '0) ? S_REPORT : S_COUNT;
                end
            end
            S_COUNT: begin
                if (r_remaining == c_win_one) begin
                    w_next = S_REPORT;
                end
            end
            S_REPORT: begin
                if (cnt_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_last      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt <= '0;
                        r_sat <= 1'b0;
                        if (window != '0) begin
                            r_last      <= sig_in;
                            r_remaining <= window;
                        end
                    end
                end
                S_COUNT: begin
                    // Saturate rather than wrap so an overflowed count never reads small.
                    if (w_change) begin
                        if (r_cnt == c_cnt_max) begin
                            r_sat <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    r_last      <= sig_in;
                    r_remaining <= r_remaining - c_win_one;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign cnt_valid = (r_state == S_REPORT);
    assign cnt_data  = r_cnt;
    assign cnt_sat   = r_sat;
    assign last_val  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_change_event_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_event_monitor
// Brief    : Drives a 1-bit/32-bit and a 4-bit/3-bit instance in lockstep and
//            compares both against a per-window change-count reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_event_monitor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cnt_ready;
    logic [15:0] window;
    logic [3:0]  sig;

    logic        busy0, valid0, sat0;
    logic [31:0] data0;
    logic [0:0]  last0;
    logic        busy1, valid1, sat1;
    logic [2:0]  data1;
    logic [3:0]  last1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] seq [0:63];
    logic [0:0] m_last0;
    logic [3:0] m_last1;
    logic [31:0] m_data0;
    logic [2:0]  m_data1;
    logic        m_sat0, m_sat1;

    change_event_monitor #(.WIDTH(1), .CNT_W(32), .WIN_W(16)) u_mon0 (
        .clk(clk), .rst_n(rst_n), .start(start), .window(window),
        .sig_in(sig[0:0]), .busy(busy0), .cnt_valid(valid0),
        .cnt_ready(cnt_ready), .cnt_data(data0), .cnt_sat(sat0), .last_val(last0)
    );

    change_event_monitor #(.WIDTH(4), .CNT_W(3), .WIN_W(8)) u_mon1 (
        .clk(clk), .rst_n(rst_n), .start(start), .window(window[7:0]),
        .sig_in(sig), .busy(busy1), .cnt_valid(valid1),
        .cnt_ready(cnt_ready), .cnt_data(data1), .cnt_sat(sat1), .last_val(last1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_result(input string tag);
        chk({tag, " valid0"}, valid0, 1'b1);
        chk({tag, " valid1"}, valid1, 1'b1);
        chk({tag, " data0"}, data0, m_data0);
        chk({tag, " sat0"}, sat0, m_sat0);
        chk({tag, " last0"}, last0, m_last0);
        chk({tag, " data1"}, data1, m_data1);
        chk({tag, " sat1"}, sat1, m_sat1);
        chk({tag, " last1"}, last1, m_last1);
    endtask

    // Reference: events are sample-to-sample differences across seq[0..w].
    task automatic model(input int w);
        int c0, c1;
        c0 = 0;
        c1 = 0;
        for (int i = 1; i <= w; i++) begin
            if (seq[i][0] != seq[i-1][0]) c0++;
            if (seq[i] != seq[i-1]) c1++;
        end
        m_data0 = 32'(c0);
        m_sat0  = 1'b0;
        m_data1 = (c1 > 7) ? 3'd7 : 3'(c1);
        m_sat1  = (c1 > 7);
        if (w != 0) begin
            m_last0 = seq[w][0];
            m_last1 = seq[w];
        end
    endtask

    task automatic run_txn(input int w, input int hold, input string tag);
        model(w);
        @(negedge clk);
        start  = 1'b1;
        window = 16'(w);
        sig    = seq[0];
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= w; i++) begin
            if (i == 1 || i == w) begin
                chk({tag, " busy"}, {busy0, busy1}, 2'b11);
                chk({tag, " early valid"}, {valid0, valid1}, 2'b00);
            end
            sig = seq[i];
            @(negedge clk);
        end
        chk({tag, " busy report"}, {busy0, busy1}, 2'b11);
        chk_result(tag);
        for (int k = 0; k < hold; k++) begin
            start  = 1'($urandom_range(0, 1));
            window = 16'($urandom_range(1, 30));
            sig    = 4'($urandom);
            @(negedge clk);
            if (k == hold - 1) chk_result({tag, " hold"});
        end
        start     = 1'($urandom_range(0, 1));
        window    = 16'($urandom_range(1, 30));
        cnt_ready = 1'b1;
        @(negedge clk);
        cnt_ready = 1'b0;
        start     = 1'b0;
        chk({tag, " idle busy"}, {busy0, busy1}, 2'b00);
        chk({tag, " idle valid"}, {valid0, valid1}, 2'b00);
        chk({tag, " idle data0"}, data0, m_data0);
        chk({tag, " idle data1"}, data1, m_data1);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cnt_ready = 1'b0;
        window    = '0;
        sig       = '0;
        m_last0   = '0;
        m_last1   = '0;
        repeat (3) @(negedge clk);
        chk("reset u0", {busy0, valid0, data0, sat0, last0}, 36'd0);
        chk("reset u1", {busy1, valid1, data1, sat1, last1}, 10'd0);
        rst_n = 1'b1;

        seq[0] = 4'h0; seq[1] = 4'h1; seq[2] = 4'h0; seq[3] = 4'h1; seq[4] = 4'h1;
        run_txn(4, 10, "win4");

        seq[0] = 4'h0; seq[1] = 4'h3; seq[2] = 4'h3; seq[3] = 4'h5;
        run_txn(3, 2, "multibit");

        seq[0] = 4'hA;
        run_txn(0, 3, "win0");

        for (int i = 0; i <= 10; i++) seq[i] = (i % 2 == 1) ? 4'hF : 4'h0;
        run_txn(10, 1, "toggle");

        for (int t = 0; t < 25; t++) begin
            int w;
            w = $urandom_range(0, 40);
            seq[0] = 4'($urandom);
            for (int i = 1; i <= w; i++)
                seq[i] = ($urandom_range(0, 2) == 0) ? seq[i-1] : 4'($urandom);
            run_txn(w, $urandom_range(0, 4), "rand");
        end

        // Abort in the middle of a window; outputs must clear without a clock edge.
        @(negedge clk);
        start  = 1'b1;
        window = 16'd20;
        sig    = 4'h5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            sig = ~sig;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("async rst u0", {busy0, valid0, data0, sat0, last0}, 36'd0);
        chk("async rst u1", {busy1, valid1, data1, sat1, last1}, 10'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_last0 = '0;
        m_last1 = '0;

        seq[0] = 4'h9; seq[1] = 4'h9; seq[2] = 4'h6; seq[3] = 4'h6; seq[4] = 4'h7;
        run_txn(4, 0, "post rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
